dma_channel_arbiter: RTL and testbench
======================================

DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 4, number of DMA channels; only 4 is supported.
REQ-002 SHALL have parameter DREQ_SYNC, default 1, giving 1 or 2 input flop stages on DREQ.
REQ-003 SHALL have port CLK  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port RESET  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port DREQ  in  4  external channel requests, polarity set by commandReg[6].
REQ-006 SHALL have port commandReg  in  8  bit2 controller disable, bit4 rotating priority, bit6 DREQ active-low, bit7 DACK active-high.
REQ-007 SHALL have port requestReg  in  8  bits[3:0] software requests, not maskable.
REQ-008 SHALL have port maskReg  in  8  bits[3:0] per-channel DREQ mask, 1 = masked.
REQ-009 SHALL have port HLDA  in  1  hold acknowledge from bus master.
REQ-010 SHALL have port svcDone  in  1  one-cycle pulse from transfer FSM marking end of the granted service.
REQ-011 SHALL have port HRQ  out  1  hold request.
REQ-012 SHALL have port DACK  out  4  channel acknowledge, polarity set by commandReg[7].
REQ-013 SHALL have port grantValid  out  1  a channel is granted to the transfer FSM.
REQ-014 SHALL have port grantCh  out  2  granted channel index, valid only when grantValid=1.

Function
REQ-015 SHALL form pend[i] = (syncDREQ[i] XOR cmd[6]) AND NOT maskReg[i], OR requestReg[i].
REQ-016 SHALL implement FSM states IDLE, WAIT_HLDA, GRANT, RELEASE.
REQ-017 IDLE: when any pend=1 and cmd[2]=0, SHALL go to WAIT_HLDA next cycle with HRQ=1.
REQ-018 IDLE with cmd[2]=1 SHALL stay idle regardless of pend.
REQ-019 WAIT_HLDA: in the first cycle HLDA=1 is sampled, SHALL pick the winner from pend in that cycle and enter GRANT next cycle.
REQ-020 WAIT_HLDA: if HLDA=1 and pend=0, SHALL go to RELEASE without granting.
REQ-021 GRANT: SHALL hold HRQ=1, grantValid=1, grantCh fixed, and assert the DACK bit of grantCh until svcDone=1.
REQ-022 GRANT: pend changes, new higher-priority requests and cmd[2] changes SHALL NOT preempt the grant.
REQ-023 svcDone in GRANT SHALL cause RELEASE next cycle with HRQ=0, grantValid=0 and DACK inactive.
REQ-024 svcDone outside GRANT SHALL be ignored.
REQ-025 RELEASE: SHALL wait for HLDA=0, then go to IDLE; a new HRQ needs at least one IDLE cycle.
REQ-026 Fixed priority (cmd[4]=0): channel 0 highest, channel 3 lowest.
REQ-027 Rotating priority (cmd[4]=1): a 2-bit pointer names the highest channel; on svcDone for channel n, pointer SHALL become (n+1) mod 4, wrapping 3 to 0.
REQ-028 The pointer SHALL update only on svcDone, also when cmd[4]=0; it SHALL be ignored while cmd[4]=0.
REQ-029 DACK SHALL be the internal one-hot dackOn XOR {4{~cmd[7]}}, combinational on cmd[7]; inactive level is 4'hF when cmd[7]=0 and 4'h0 when cmd[7]=1.
REQ-030 Winner selection SHALL be combinational on pend and pointer and registered into grantCh at the GRANT entry edge.

Reset
REQ-031 RESET=1 SHALL force, asynchronously: state=IDLE, pointer=0, HRQ=0, grantValid=0, grantCh=0, dackOn=0, DREQ sync flops=0.
REQ-032 Reset mid-GRANT SHALL drop HRQ and DACK immediately; no svcDone is required.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, NCH, and the command bit index constants CMD_DIS=2, CMD_ROT=4, CMD_DREQ_LO=6, CMD_DACK_HI=7.
REQ-034 The rotating priority encoder SHALL be the sub-module dma_prio_enc: inputs pend[3:0] and ptr[1:0], outputs any and win[1:0]; fully combinational.

Verification
REQ-035 Fixed priority: cmd=0x00, DREQ=1010, HLDA after 2 cycles -> grantCh=1, DACK=1101; svcDone -> RELEASE, then ch3 granted in the next round.
REQ-036 Rotating priority: cmd=0x10, all 4 DREQ held, svcDone after each grant -> grant order 0,1,2,3,0.
REQ-037 Masking and software request: maskReg=0x0F, DREQ=1111, requestReg=0x04 -> only ch2 granted; with requestReg=0 -> HRQ stays 0.
REQ-038 Polarity: cmd=0xC0, DREQ=1110 -> ch0 granted, DACK=0001.
REQ-039 Disable: cmd=0x04, pend=1111 -> HRQ stays 0; setting cmd[2] while in GRANT -> grant holds until svcDone.
REQ-040 Reset in GRANT: assert RESET mid-cycle -> HRQ=0 and DACK=4'hF before the next edge; pointer=0.

Source files
------------

// File: rtl/dma_channel_arbiter_pkg.sv
// rtl/dma_channel_arbiter_pkg.sv - shared constants and FSM encoding for the DMA channel arbiter
package dma_channel_arbiter_pkg;

    localparam int NCH = 4;

    localparam int CMD_DIS     = 2;
    localparam int CMD_ROT     = 4;
    localparam int CMD_DREQ_LO = 6;
    localparam int CMD_DACK_HI = 7;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HLDA = 2'd1,
        ST_GRANT     = 2'd2,
        ST_RELEASE   = 2'd3
    } arbState_t;

endpackage

// File: rtl/dma_prio_enc.sv
// rtl/dma_prio_enc.sv - combinational rotating priority encoder, ptr names the highest-priority channel
module dma_prio_enc
    import dma_channel_arbiter_pkg::*;
(
    input  logic [NCH-1:0] pend,
    input  logic [1:0]     ptr,
    output logic           any,
    output logic [1:0]     win
);

    logic [1:0] idx;

    // Scan from lowest to highest priority so the highest-priority hit is written last
    always_comb begin
        any = 1'b0;
        win = ptr;
        idx = ptr;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (pend[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

endmodule

// File: rtl/dma_channel_arbiter.sv
// rtl/dma_channel_arbiter.sv - DREQ/software request arbiter with HRQ/HLDA handshake and DACK generation
module dma_channel_arbiter #(
    parameter int NCH       = 4,
    parameter int DREQ_SYNC = 1
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [NCH-1:0] DREQ,
    input  logic [7:0]     commandReg,
    input  logic [7:0]     requestReg,
    input  logic [7:0]     maskReg,
    input  logic           HLDA,
    input  logic           svcDone,
    output logic           HRQ,
    output logic [NCH-1:0] DACK,
    output logic           grantValid,
    output logic [1:0]     grantCh
);
    import dma_channel_arbiter_pkg::*;

    localparam logic [1:0] IDLE      = ST_IDLE;
    localparam logic [1:0] WAIT_HLDA = ST_WAIT_HLDA;
    localparam logic [1:0] GRANT     = ST_GRANT;
    localparam logic [1:0] RELEASE   = ST_RELEASE;

    logic [1:0]     state;
    logic [1:0]     pointer;
    logic [NCH-1:0] dackOn;
    logic [NCH-1:0] syncStage [2];
    logic [NCH-1:0] syncDREQ;
    logic [NCH-1:0] pend;
    logic [1:0]     encPtr;
    logic [1:0]     win;
    logic           anyPend;
    logic           unusedBits;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            syncStage[0] <= '0;
            syncStage[1] <= '0;
        end else begin
            syncStage[0] <= DREQ;
            syncStage[1] <= syncStage[0];
        end
    end

    assign syncDREQ = (DREQ_SYNC == 2) ? syncStage[1] : syncStage[0];

    // Software requests bypass both the mask and the DREQ polarity
    assign pend = ((syncDREQ ^ {NCH{commandReg[CMD_DREQ_LO]}}) & ~maskReg[NCH-1:0])
                | requestReg[NCH-1:0];

    assign encPtr = commandReg[CMD_ROT] ? pointer : 2'd0;

    dma_prio_enc u_prioEnc (
        .pend (pend),
        .ptr  (encPtr),
        .any  (anyPend),
        .win  (win)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            pointer    <= 2'd0;
            grantValid <= 1'b0;
            grantCh    <= 2'd0;
            dackOn     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyPend && !commandReg[CMD_DIS])
                        state <= WAIT_HLDA;
                end
                WAIT_HLDA: begin
                    if (HLDA) begin
                        if (anyPend) begin
                            state      <= GRANT;
                            grantValid <= 1'b1;
                            grantCh    <= win;
                            dackOn     <= NCH'(1) << win;
                        end else begin
                            state <= RELEASE;
                        end
                    end
                end
                GRANT: begin
                    // Only svcDone ends a grant; request and command changes are ignored here
                    if (svcDone) begin
                        state      <= RELEASE;
                        grantValid <= 1'b0;
                        dackOn     <= '0;
                        pointer    <= grantCh + 2'd1;
                    end
                end
                RELEASE: begin
                    if (!HLDA)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded from state so reset drops HRQ without waiting for an edge
    assign HRQ  = (state == WAIT_HLDA) || (state == GRANT);
    assign DACK = dackOn ^ {NCH{~commandReg[CMD_DACK_HI]}};

    assign unusedBits = ^{commandReg[5], commandReg[3], commandReg[1:0],
                          requestReg[7:4], maskReg[7:4]};

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb/tb_dma_channel_arbiter.sv - scoreboard bench for dma_channel_arbiter
module tb_dma_channel_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ;
    logic [7:0] commandReg;
    logic [7:0] requestReg;
    logic [7:0] maskReg;
    logic       HLDA;
    logic       svcDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic       grantValid;
    logic [1:0] grantCh;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        logic [1:0] ch;
        logic [3:0] dack;
    } exp_t;

    exp_t expQ[$];
    exp_t expItem;
    logic prevGv = 1'b0;

    dma_channel_arbiter #(.NCH(4), .DREQ_SYNC(1)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .DREQ       (DREQ),
        .commandReg (commandReg),
        .requestReg (requestReg),
        .maskReg    (maskReg),
        .HLDA       (HLDA),
        .svcDone    (svcDone),
        .HRQ        (HRQ),
        .DACK       (DACK),
        .grantValid (grantValid),
        .grantCh    (grantCh)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [1:0] ch, input logic [3:0] dack);
        exp_t e;
        e.ch   = ch;
        e.dack = dack;
        expQ.push_back(e);
    endtask

    // Monitor: every new grant is compared against the oldest expectation
    initial begin
        forever begin
            @(negedge CLK);
            if (grantValid === 1'b1 && !prevGv) begin
                if (expQ.size() == 0) begin
                    assertions++;
                    failures++;
                    $display("FAIL sb_unexpected: grant ch %0d with no expectation", grantCh);
                end else begin
                    expItem = expQ.pop_front();
                    check("sb_grantCh", 32'(grantCh), 32'(expItem.ch));
                    check("sb_dack", 32'(DACK), 32'(expItem.dack));
                end
            end
            prevGv = (grantValid === 1'b1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic doReset(input logic [7:0] cmd);
        logic [3:0] inact;
        inact      = cmd[7] ? 4'h0 : 4'hF;
        commandReg = cmd;
        RESET      = 1'b1;
        DREQ       = 4'h0;
        requestReg = 8'h00;
        maskReg    = 8'h00;
        HLDA       = 1'b0;
        svcDone    = 1'b0;
        #1;
        check("rst_hrq", 32'(HRQ), 32'd0);
        check("rst_gv", 32'(grantValid), 32'd0);
        check("rst_grantCh", 32'(grantCh), 32'd0);
        check("rst_dack", 32'(DACK), 32'(inact));
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic waitHrq(input logic lvl, input string name);
        int n;
        for (n = 0; n < 30; n++) begin
            @(negedge CLK);
            if (HRQ === lvl) break;
        end
        assertions++;
        if (n == 30) begin
            failures++;
            $display("FAIL %s: HRQ never reached %0d, got %0b", name, lvl, HRQ);
        end
    endtask

    task automatic waitGv();
        int n;
        for (n = 0; n < 30; n++) begin
            @(negedge CLK);
            if (grantValid === 1'b1) break;
        end
        assertions++;
        if (n == 30) begin
            failures++;
            $display("FAIL grant_timeout: grantValid got %0b expected 1", grantValid);
        end
    endtask

    task automatic startGrant(input int hldaDelay);
        waitHrq(1'b1, "hrq_rise");
        repeat (hldaDelay) @(posedge CLK);
        #1 HLDA = 1'b1;
        waitGv();
    endtask

    task automatic endSvc(input logic [3:0] inact);
        @(posedge CLK); #1 svcDone = 1'b1;
        @(posedge CLK); #1 svcDone = 1'b0;
        check("rel_hrq", 32'(HRQ), 32'd0);
        check("rel_gv", 32'(grantValid), 32'd0);
        check("rel_dack", 32'(DACK), 32'(inact));
        HLDA = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        int seen;
        logic [3:0] oh;

        // Fixed priority, ch1 then ch3
        doReset(8'h00);
        DREQ = 4'b1010;
        pushExp(2'd1, 4'b1101);
        startGrant(2);
        DREQ = 4'b1000;
        endSvc(4'hF);
        pushExp(2'd3, 4'b0111);
        startGrant(1);
        DREQ = 4'b0000;
        endSvc(4'hF);

        // Rotating priority with every channel requesting
        doReset(8'h10);
        DREQ = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << (i % 4);
            pushExp(2'(i % 4), ~oh);
            startGrant(1);
            if (i == 4) DREQ = 4'b0000;
            endSvc(4'hF);
        end

        // Mask blocks DREQ, software request still wins
        doReset(8'h00);
        maskReg    = 8'h0F;
        DREQ       = 4'b1111;
        requestReg = 8'h04;
        pushExp(2'd2, 4'b1011);
        startGrant(1);
        requestReg = 8'h00;
        endSvc(4'hF);
        seen = 0;
        repeat (10) begin
            @(negedge CLK);
            if (HRQ !== 1'b0) seen = 1;
        end
        check("mask_no_hrq", 32'(seen), 32'd0);

        // Active-low DREQ, active-high DACK
        doReset(8'hC0);
        DREQ = 4'b1110;
        pushExp(2'd0, 4'b0001);
        startGrant(2);
        DREQ = 4'b1111;
        endSvc(4'h0);

        // Controller disable, then disable during a grant
        doReset(8'h04);
        DREQ = 4'b1111;
        seen = 0;
        repeat (10) begin
            @(negedge CLK);
            if (HRQ !== 1'b0) seen = 1;
        end
        check("dis_no_hrq", 32'(seen), 32'd0);
        commandReg = 8'h00;
        pushExp(2'd0, 4'b1110);
        startGrant(1);
        commandReg = 8'h04;
        DREQ       = 4'b0000;
        repeat (4) @(negedge CLK);
        check("dis_hold_gv", 32'(grantValid), 32'd1);
        check("dis_hold_hrq", 32'(HRQ), 32'd1);
        check("dis_hold_ch", 32'(grantCh), 32'd0);
        check("dis_hold_dack", 32'(DACK), 32'(4'b1110));
        endSvc(4'hF);

        // Reset in the middle of a grant, pointer must return to 0
        doReset(8'h10);
        DREQ = 4'b0010;
        pushExp(2'd1, 4'b1101);
        startGrant(1);
        @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        check("midrst_hrq", 32'(HRQ), 32'd0);
        check("midrst_dack", 32'(DACK), 32'hF);
        check("midrst_gv", 32'(grantValid), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        HLDA  = 1'b0;
        DREQ  = 4'b1111;
        pushExp(2'd0, 4'b1110);
        startGrant(1);
        DREQ = 4'b0000;
        endSvc(4'hF);

        repeat (5) @(posedge CLK);
        check("sb_drain", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
